// File: rtl/alu_sequencer_if.sv
// Instruction handshake and register-file/ALU bus of the ALU sequencer.
// master: upstream instruction source plus register file and ALU.
// slave:  the sequencer itself.
interface alu_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [17:0] instr;
    logic [4:0]  readreg1;
    logic [4:0]  readreg2;
    logic [1:0]  alu_op;
    logic [31:0] sig2;
    logic [63:0] alu_out;
    logic [4:0]  writereg;
    logic        wr_op;
    logic [31:0] data_in;

    modport master (
        output instr_valid, instr, sig2, alu_out,
        input  instr_ready, readreg1, readreg2, alu_op, writereg, wr_op, data_in
    );

    modport slave (
        input  instr_valid, instr, sig2, alu_out,
        output instr_ready, readreg1, readreg2, alu_op, writereg, wr_op, data_in
    );
endinterface

// File: rtl/alu_sequencer.sv
// Four-cycle instruction sequencer: accepts an 18-bit instruction, drives
// register-file read addresses and the ALU opcode, captures the ALU result,
// writes back through the register-file port and retires the instruction
// with a done pulse, counter increment and sticky error flags.
module alu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    alu_sequencer_if.slave   bus,
    output logic [31:0]      hi_out,
    output logic             done,
    output logic             err_div0,
    output logic             err_illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched instruction fields; rs1/rs2 double as the LDI immediate.
    logic [2:0]       r_opc;
    logic [4:0]       r_rd;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;

    // Opcode classification, valid from EXEC onwards.
    logic             r_is_ldi;
    logic             r_is_mul;
    logic             r_is_div;
    logic             r_illegal;

    // Execution results.
    logic [63:0]      r_result;
    logic             r_write_ok;
    logic [31:0]      r_hi;
    logic             r_done;
    logic             r_err_div0;
    logic             r_err_illegal;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_div0;
    logic             w_ready;
    logic             w_wr_op;
    logic [4:0]       w_writereg;
    logic [31:0]      w_data_in;

    assign w_accept = (r_state == S_IDLE) && bus.instr_valid;
    assign w_div0   = r_is_div && (bus.sig2 == '0);

    // State register; clr returns to IDLE and drops any instruction in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded handshake/write-back outputs.
    always_comb begin
        w_next     = r_state;
        w_ready    = 1'b0;
        w_wr_op    = 1'b0;
        w_writereg = '0;
        w_data_in  = '0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.instr_valid) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                w_next = S_WB;
            end
            S_WB: begin
                w_next = S_IDLE;
                if (r_write_ok) begin
                    w_wr_op    = 1'b1;
                    w_writereg = r_rd;
                    w_data_in  = r_is_ldi ? {22'b0, r_rs1, r_rs2} : r_result[31:0];
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Instruction latch on the accept edge; fields hold until the next accept.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_opc <= '0;
            r_rd  <= '0;
            r_rs1 <= '0;
            r_rs2 <= '0;
        end else if (w_accept) begin
            r_opc <= bus.instr[17:15];
            r_rd  <= bus.instr[14:10];
            r_rs1 <= bus.instr[9:5];
            r_rs2 <= bus.instr[4:0];
        end
    end

    // Opcode classification at the end of DECODE.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_is_ldi  <= 1'b0;
            r_is_mul  <= 1'b0;
            r_is_div  <= 1'b0;
            r_illegal <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_is_ldi  <= (r_opc == 3'b100);
            r_is_mul  <= (r_opc == 3'b010);
            r_is_div  <= (r_opc == 3'b011);
            r_illegal <= r_opc[2] && (r_opc[1:0] != 2'b00);
        end
    end

    // Result capture, write qualification and sticky error flags at end of EXEC.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_result      <= '0;
            r_write_ok    <= 1'b0;
            r_err_div0    <= 1'b0;
            r_err_illegal <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_result   <= bus.alu_out;
            r_write_ok <= !r_illegal && !w_div0;
            if (w_div0) begin
                r_err_div0 <= 1'b1;
            end
            if (r_illegal) begin
                r_err_illegal <= 1'b1;
            end
        end
    end

    // Retirement at the end of WB: done pulse, counter, MUL high word.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_done  <= 1'b0;
            r_count <= '0;
            r_hi    <= '0;
        end else begin
            r_done <= (r_state == S_WB);
            if (r_state == S_WB) begin
                r_count <= r_count + CNT_W'(1);
                if (r_is_mul) begin
                    r_hi <= r_result[63:32];
                end
            end
        end
    end

    assign bus.instr_ready = w_ready;
    assign bus.readreg1    = r_rs1;
    assign bus.readreg2    = r_rs2;
    assign bus.alu_op      = r_opc[1:0];
    assign bus.wr_op       = w_wr_op;
    assign bus.writereg    = w_writereg;
    assign bus.data_in     = w_data_in;

    assign hi_out      = r_hi;
    assign done        = r_done;
    assign err_div0    = r_err_div0;
    assign err_illegal = r_err_illegal;
    assign instr_count = r_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: an environment register file and
// ALU answer the DUT's bus, while a per-instruction reference model predicts
// write-back data, hi_out, error flags and the retired count.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] hi_out;
    logic        done;
    logic        err_div0;
    logic        err_illegal;
    logic [15:0] instr_count;

    int total = 0;
    int bad   = 0;

    alu_sequencer_if bus ();

    always #5 clk = ~clk;

    alu_sequencer #(.CNT_W(16)) dut (
        .clk         (clk),
        .clr         (clr),
        .bus         (bus),
        .hi_out      (hi_out),
        .done        (done),
        .err_div0    (err_div0),
        .err_illegal (err_illegal),
        .instr_count (instr_count)
    );

    // Environment: register file written on the falling edge, combinational ALU.
    logic [31:0] rf [32] = '{default: '0};
    logic [31:0] env_a;
    logic [31:0] env_b;

    always @(negedge clk) begin
        if (bus.wr_op === 1'b1) rf[bus.writereg] <= bus.data_in;
    end

    always_comb begin
        env_a   = rf[bus.readreg1];
        env_b   = rf[bus.readreg2];
        bus.sig2 = env_b;
        case (bus.alu_op)
            2'd0:    bus.alu_out = {32'b0, env_a + env_b};
            2'd1:    bus.alu_out = {32'b0, env_a - env_b};
            2'd2:    bus.alu_out = {32'b0, env_a} * {32'b0, env_b};
            default: bus.alu_out = (env_b == 0) ? 64'h0 : {32'b0, env_a / env_b};
        endcase
    end

    // Reference model state.
    logic [31:0] mrf [32] = '{default: '0};
    logic [31:0] m_hi;
    logic        m_div0;
    logic        m_ill;
    logic [15:0] m_count;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_count"}, instr_count, m_count);
        chk({tag, "_hi"}, hi_out, m_hi);
        chk({tag, "_div0"}, err_div0, m_div0);
        chk({tag, "_ill"}, err_illegal, m_ill);
    endtask

    task automatic wait_ready(input string tag);
        int w = 0;
        while (bus.instr_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_accept_timeout"}, (w < 20), 1'b1);
    endtask

    // Issue one instruction and check every phase against the model.
    task automatic issue(input logic [2:0] opc, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        logic [31:0] a, b, res;
        logic [63:0] p;
        logic        wr;
        a   = mrf[rs1];
        b   = mrf[rs2];
        wr  = 1'b1;
        res = '0;
        case (opc)
            3'd0: res = a + b;
            3'd1: res = a - b;
            3'd2: begin
                p    = {32'b0, a} * {32'b0, b};
                res  = p[31:0];
                m_hi = p[63:32];
            end
            3'd3: begin
                if (b == 0) begin
                    wr     = 1'b0;
                    m_div0 = 1'b1;
                end else begin
                    res = a / b;
                end
            end
            3'd4: res = {22'b0, rs1, rs2};
            default: begin
                wr    = 1'b0;
                m_ill = 1'b1;
            end
        endcase
        m_count++;

        @(negedge clk);
        bus.instr       = {opc, rd, rs1, rs2};
        bus.instr_valid = 1'b1;
        wait_ready("issue");
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("dec_ready", bus.instr_ready, 1'b0);
        chk("dec_readreg1", bus.readreg1, rs1);
        chk("dec_readreg2", bus.readreg2, rs2);
        chk("dec_alu_op", bus.alu_op, opc[1:0]);
        @(negedge clk);
        chk("exec_wr_op", bus.wr_op, 1'b0);
        chk("exec_readreg1", bus.readreg1, rs1);
        @(negedge clk);
        chk("wb_wr_op", bus.wr_op, wr);
        chk("wb_done", done, 1'b0);
        chk("wb_alu_op", bus.alu_op, opc[1:0]);
        if (wr) begin
            chk("wb_writereg", bus.writereg, rd);
            chk("wb_data_in", bus.data_in, res);
        end
        @(negedge clk);
        chk("ret_done", done, 1'b1);
        chk("ret_wr_op", bus.wr_op, 1'b0);
        chk("ret_ready", bus.instr_ready, 1'b1);
        chk_status("ret");
        if (wr) mrf[rd] = res;
    endtask

    // instr_valid held high across three back-to-back LDIs.
    task automatic cont_ldi(input logic [4:0] rd, input logic [9:0] imm);
        @(negedge clk);
        bus.instr       = {3'b100, rd, imm};
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk("cont_ready", bus.instr_ready, (k % 4 == 0));
            chk("cont_wr_op", bus.wr_op, (k % 4 == 3));
            if (k % 4 == 3) chk("cont_data_in", bus.data_in, {22'b0, imm});
            if (k > 0 && k % 4 == 0) begin
                m_count++;
                chk("cont_done", done, 1'b1);
                chk("cont_count", instr_count, m_count);
            end
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        m_count++;
        chk("cont_last_done", done, 1'b1);
        chk("cont_last_count", instr_count, m_count);
        mrf[rd] = {22'b0, imm};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [2:0] opc;
        clr             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        m_hi            = '0;
        m_div0          = 1'b0;
        m_ill           = 1'b0;
        m_count         = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.instr_ready, 1'b1);
        chk("rst_wr_op", bus.wr_op, 1'b0);
        chk("rst_data_in", bus.data_in, 32'h0);
        chk("rst_writereg", bus.writereg, 5'h0);
        chk("rst_readreg1", bus.readreg1, 5'h0);
        chk("rst_readreg2", bus.readreg2, 5'h0);
        chk("rst_alu_op", bus.alu_op, 2'h0);
        chk("rst_done", done, 1'b0);
        chk_status("rst");
        clr = 1'b0;

        // LDI r3 = 0x2A.
        issue(3'd4, 5'd3, 5'd1, 5'd10);
        chk("ldi_r3_literal", mrf[3], 32'h2A);

        // Arithmetic on r1=7, r2=5.
        issue(3'd4, 5'd1, 5'd0, 5'd7);
        issue(3'd4, 5'd2, 5'd0, 5'd5);
        issue(3'd0, 5'd4, 5'd1, 5'd2);
        issue(3'd1, 5'd5, 5'd1, 5'd2);
        issue(3'd2, 5'd6, 5'd1, 5'd2);
        issue(3'd3, 5'd7, 5'd1, 5'd2);

        // 0xFFFFFFFF * 2 via r8 = r0 - 1.
        issue(3'd4, 5'd9, 5'd0, 5'd1);
        issue(3'd1, 5'd8, 5'd0, 5'd9);
        issue(3'd4, 5'd10, 5'd0, 5'd2);
        issue(3'd2, 5'd11, 5'd8, 5'd10);
        chk("mul_big_hi_literal", hi_out, 32'h1);

        // Back-to-back acceptance.
        cont_ldi(5'd12, 10'h155);

        // Divide by zero (r20 never written), then illegal opcode.
        issue(3'd3, 5'd13, 5'd1, 5'd20);
        issue(3'd7, 5'd14, 5'd1, 5'd2);
        issue(3'd0, 5'd15, 5'd1, 5'd2);

        // clr wins over instr_valid.
        @(negedge clk);
        clr             = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr       = {3'b100, 5'd16, 10'h3FF};
        m_count         = '0;
        m_hi            = '0;
        m_div0          = 1'b0;
        m_ill           = 1'b0;
        @(negedge clk);
        clr             = 1'b0;
        bus.instr_valid = 1'b0;
        chk("clrwin_ready", bus.instr_ready, 1'b1);
        chk("clrwin_readreg1", bus.readreg1, 5'h0);
        chk_status("clrwin");
        repeat (4) @(negedge clk);
        chk("clrwin_later_done", done, 1'b0);
        chk("clrwin_later_count", instr_count, m_count);

        // clr during EXEC of an ADD aborts it.
        issue(3'd2, 5'd6, 5'd1, 5'd2);
        @(negedge clk);
        bus.instr       = {3'b000, 5'd17, 5'd1, 5'd2};
        bus.instr_valid = 1'b1;
        wait_ready("abort");
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr     = 1'b0;
        m_count = '0;
        m_hi    = '0;
        chk("abort_wr_op", bus.wr_op, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_ready", bus.instr_ready, 1'b1);
        chk("abort_data_in", bus.data_in, 32'h0);
        chk_status("abort");
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_wr", bus.wr_op, 1'b0);
            chk("abort_no_done", done, 1'b0);
            @(negedge clk);
        end
        chk("abort_rf_untouched", rf[17], mrf[17]);
        issue(3'd0, 5'd17, 5'd1, 5'd2);

        // Randomized instructions.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) opc = 3'($urandom_range(5, 7));
            else                           opc = 3'($urandom_range(0, 4));
            issue(opc, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)));
        end
        for (int r = 0; r < 32; r++) chk("final_rf", rf[r], mrf[r]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
